// File: rtl/sirv_pwm_dt_pkg.sv
// Shared definitions for the PWM dead-time block: channel state encoding,
// default widths and the state-to-gate-drive decode.
package sirv_pwm_dt_pkg;

  localparam int CH_NUM_DEF = 4;
  localparam int DT_W_DEF   = 8;

  localparam logic [2:0] ENC_OFF  = 3'd0;
  localparam logic [2:0] ENC_LO   = 3'd1;
  localparam logic [2:0] ENC_DT_R = 3'd2;
  localparam logic [2:0] ENC_HI   = 3'd3;
  localparam logic [2:0] ENC_DT_F = 3'd4;

  typedef enum logic [2:0] {
    ST_OFF  = ENC_OFF,
    ST_LO   = ENC_LO,
    ST_DT_R = ENC_DT_R,
    ST_HI   = ENC_HI,
    ST_DT_F = ENC_DT_F
  } dt_state_e;

  // Gate drive for a state as {hi, lo}. Only HI and LO drive anything, so
  // the two sides can never be on together.
  function automatic logic [1:0] decode_drive(input dt_state_e s);
    logic [1:0] d;
    d = 2'b00;
    if (s == ST_HI) d = 2'b10;
    if (s == ST_LO) d = 2'b01;
    return d;
  endfunction

endpackage

// File: rtl/sirv_pwm_dt_chnl.sv
// One complementary gate-drive channel: FSM, dead-time counter and
// registered output decode.
module sirv_pwm_dt_chnl
  import sirv_pwm_dt_pkg::*;
#(
  parameter int DT_W = DT_W_DEF
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            pwm_q,   // registered PWM level
  input  logic            run,     // en and no latched fault
  input  logic [DT_W-1:0] dt_cfg,
  output logic            out_hi,
  output logic            out_lo,
  output dt_state_e       state    // exposed for debug / checkers
);

  dt_state_e       state_nxt;
  logic [DT_W-1:0] cnt;
  logic [DT_W-1:0] cnt_nxt;
  logic            dt_zero;
  logic            cnt_last;
  logic [1:0]      drive_nxt;

  assign dt_zero   = (dt_cfg == '0);
  assign cnt_last  = (cnt == DT_W'(1));
  assign drive_nxt = decode_drive(state_nxt);

  // Next-state logic. A disabled or faulted channel drops to OFF from any
  // state and discards a running count. dt_cfg is read only when a count
  // is loaded, so changes mid-count affect only the next dead-time.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    if (!run) begin
      state_nxt = ST_OFF;
      cnt_nxt   = '0;
    end else begin
      case (state)
        ST_OFF: begin
          state_nxt = ST_LO;
        end
        ST_LO: begin
          if (pwm_q) begin
            if (dt_zero) begin
              state_nxt = ST_HI;
            end else begin
              state_nxt = ST_DT_R;
              cnt_nxt   = dt_cfg;
            end
          end
        end
        ST_DT_R: begin
          // A high pulse that ends inside the dead-time is swallowed and
          // the low side comes straight back.
          if (!pwm_q) begin
            state_nxt = ST_LO;
          end else if (cnt_last) begin
            state_nxt = ST_HI;
          end else begin
            cnt_nxt = cnt - DT_W'(1);
          end
        end
        ST_HI: begin
          if (!pwm_q) begin
            if (dt_zero) begin
              state_nxt = ST_LO;
            end else begin
              state_nxt = ST_DT_F;
              cnt_nxt   = dt_cfg;
            end
          end
        end
        ST_DT_F: begin
          if (pwm_q) begin
            state_nxt = ST_HI;
          end else if (cnt_last) begin
            state_nxt = ST_LO;
          end else begin
            cnt_nxt = cnt - DT_W'(1);
          end
        end
        default: begin
          state_nxt = ST_OFF;
          cnt_nxt   = '0;
        end
      endcase
    end
  end

  // State, counter and glitch-free registered gate outputs. The outputs are
  // decoded from the next state so they always match the state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= ST_OFF;
      cnt    <= '0;
      out_hi <= 1'b0;
      out_lo <= 1'b0;
    end else begin
      state  <= state_nxt;
      cnt    <= cnt_nxt;
      out_hi <= drive_nxt[1];
      out_lo <= drive_nxt[0];
    end
  end

endmodule

// File: rtl/sirv_pwm_deadtime.sv
// PWM dead-time generator: turns each PWM compare output into a
// complementary high/low gate-drive pair with a sticky fault kill.
module sirv_pwm_deadtime
  import sirv_pwm_dt_pkg::*;
#(
  parameter int CH_NUM = CH_NUM_DEF,
  parameter int DT_W   = DT_W_DEF
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [CH_NUM-1:0]   pwm_in,
  input  logic                en,
  input  logic [DT_W-1:0]     dt_cfg,
  input  logic                kill,
  input  logic                kill_clr,
  output logic [CH_NUM-1:0]   out_hi,
  output logic [CH_NUM-1:0]   out_lo,
  output logic                kill_sts,
  output logic [3*CH_NUM-1:0] dbg_state  // per-channel state, 3 bits each
);

  logic [CH_NUM-1:0] pwm_q;
  logic              run;

  // Single register stage on the raw PWM levels; all channels see pwm_q.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pwm_q <= '0;
    end else begin
      pwm_q <= pwm_in;
    end
  end

  // Sticky fault latch. kill takes priority over a simultaneous kill_clr.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      kill_sts <= 1'b0;
    end else if (kill) begin
      kill_sts <= 1'b1;
    end else if (kill_clr) begin
      kill_sts <= 1'b0;
    end
  end

  assign run = en & ~kill_sts;

  for (genvar i = 0; i < CH_NUM; i++) begin : g_ch
    dt_state_e ch_state;

    sirv_pwm_dt_chnl #(
      .DT_W (DT_W)
    ) u_chnl (
      .clk    (clk),
      .rst_n  (rst_n),
      .pwm_q  (pwm_q[i]),
      .run    (run),
      .dt_cfg (dt_cfg),
      .out_hi (out_hi[i]),
      .out_lo (out_lo[i]),
      .state  (ch_state)
    );

    assign dbg_state[3*i +: 3] = ch_state;
  end

endmodule

// File: tb/tb_sirv_pwm_deadtime.sv
// Self-checking bench for sirv_pwm_deadtime: directed scenarios with
// hand-computed cycle counts plus a randomized run checked every cycle
// against a behavioural model.
module tb_sirv_pwm_deadtime;

  localparam int CH = 4;
  localparam int DW = 8;

  // ---------------- clock / reset ----------------
  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [CH-1:0]   pwm_in = '0;
  logic            en = 1'b1;
  logic [DW-1:0]   dt_cfg = 8'd5;
  logic            kill = 1'b0;
  logic            kill_clr = 1'b0;
  logic [CH-1:0]   out_hi;
  logic [CH-1:0]   out_lo;
  logic            kill_sts;
  logic [3*CH-1:0] dbg_state;

  always #5 clk = ~clk;

  sirv_pwm_deadtime #(.CH_NUM(CH), .DT_W(DW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .pwm_in    (pwm_in),
    .en        (en),
    .dt_cfg    (dt_cfg),
    .kill      (kill),
    .kill_clr  (kill_clr),
    .out_hi    (out_hi),
    .out_lo    (out_lo),
    .kill_sts  (kill_sts),
    .dbg_state (dbg_state)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Each channel is described by the side it is settled on (0 none, 1 low,
  // 2 high) plus, while swapping, the side it is heading for and how many
  // more cycles of gap remain. Outputs are on only when settled.
  int            m_side[CH];
  int            m_tgt[CH];
  int            m_gap[CH];
  logic [CH-1:0] m_pq;
  logic          m_ks;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int c = 0; c < CH; c++) begin
        m_side[c] = 0;
        m_tgt[c]  = 0;
        m_gap[c]  = 0;
      end
      m_pq = '0;
      m_ks = 1'b0;
    end else begin
      for (int c = 0; c < CH; c++) begin
        int want;
        want = m_pq[c] ? 2 : 1;
        if (m_ks || !en) begin
          m_side[c] = 0;
          m_gap[c]  = 0;
        end else if (m_side[c] == 0) begin
          m_side[c] = 1;
        end else if (m_gap[c] > 0) begin
          if (want != m_tgt[c]) begin
            m_gap[c] = 0;                 // pulse too short: stay put
          end else if (m_gap[c] == 1) begin
            m_side[c] = m_tgt[c];
            m_gap[c]  = 0;
          end else begin
            m_gap[c] = m_gap[c] - 1;
          end
        end else if (want != m_side[c]) begin
          if (dt_cfg == '0) begin
            m_side[c] = want;
          end else begin
            m_tgt[c] = want;
            m_gap[c] = int'(dt_cfg);
          end
        end
      end
      if (kill) m_ks = 1'b1;
      else if (kill_clr) m_ks = 1'b0;
      m_pq = pwm_in;
    end
  end

  function automatic logic [CH-1:0] exp_hi();
    logic [CH-1:0] r;
    for (int c = 0; c < CH; c++) r[c] = (m_side[c] == 2) && (m_gap[c] == 0);
    return r;
  endfunction

  function automatic logic [CH-1:0] exp_lo();
    logic [CH-1:0] r;
    for (int c = 0; c < CH; c++) r[c] = (m_side[c] == 1) && (m_gap[c] == 0);
    return r;
  endfunction

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (rst_n) begin
      check("out_hi", 32'(out_hi), 32'(exp_hi()));
      check("out_lo", 32'(out_lo), 32'(exp_lo()));
      check("kill_sts", 32'(kill_sts), 32'(m_ks));
      check("no_overlap", 32'(out_hi & out_lo), 32'd0);
      for (int c = 0; c < CH; c++)
        check("state_legal", 32'(dbg_state[3*c +: 3] <= 3'd4), 32'd1);
    end
  end

  // ---------------- driver tasks ----------------
  // Starting settled on the low side, raise pwm_in[ch] for h cycles and
  // count, over 30 samples, cycles with the high side on and cycles with
  // both sides off. dt_cfg switches from dt0 to dt1 during the first gap.
  task automatic run_pulse(input string tag, input int ch, input int h,
                           input int dt0, input int dt1,
                           input int exp_hi_n, input int exp_dead_n);
    int n_hi;
    int n_dead;
    n_hi   = 0;
    n_dead = 0;
    dt_cfg = DW'(dt0);
    @(posedge clk); #1;
    pwm_in[ch] = 1'b1;
    for (int i = 0; i < 30; i++) begin
      @(posedge clk); #1;
      if (out_hi[ch]) n_hi++;
      if (!out_hi[ch] && !out_lo[ch]) n_dead++;
      if (i == h - 1) pwm_in[ch] = 1'b0;
      if (i == 2) dt_cfg = DW'(dt1);
    end
    check({tag, "_hi_cycles"}, 32'(n_hi), 32'(exp_hi_n));
    check({tag, "_dead_cycles"}, 32'(n_dead), 32'(exp_dead_n));
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    tick(3);
    check("reset_out_lo", 32'(out_lo), 32'd0);
    check("reset_out_hi", 32'(out_hi), 32'd0);
    check("reset_kill_sts", 32'(kill_sts), 32'd0);
    rst_n = 1'b1;
    tick(2);
    check("startup_out_lo", 32'(out_lo), 32'hF);
    check("startup_out_hi", 32'(out_hi), 32'h0);

    // 50% duty, 20-cycle period, D=5: 5 high cycles and two 5-cycle gaps
    run_pulse("pwm50_a", 0, 10, 5, 5, 5, 10);
    run_pulse("pwm50_b", 0, 10, 5, 5, 5, 10);
    // 3-cycle glitch under a 5-cycle dead-time: no high pulse, 3-cycle gap
    run_pulse("glitch", 1, 3, 5, 5, 0, 3);
    // no dead-time: sides swap on one edge, no gap
    run_pulse("dt0", 2, 10, 0, 0, 10, 0);
    // dt changes 10 -> 2 during the first gap: gaps of 10 and 2
    run_pulse("dt_change", 3, 20, 10, 2, 10, 12);

    // kill during a rising dead-time on ch2
    dt_cfg = 8'd5;
    pwm_in[2] = 1'b1;
    tick(3);
    check("kill_pre_dt", 32'({out_hi[2], out_lo[2]}), 32'd0);
    kill = 1'b1;
    tick(1);
    kill_clr = 1'b1;
    tick(1);
    check("kill_out_hi", 32'(out_hi), 32'd0);
    check("kill_out_lo", 32'(out_lo), 32'd0);
    check("kill_wins_clr", 32'(kill_sts), 32'd1);
    kill = 1'b0;
    kill_clr = 1'b0;
    pwm_in[2] = 1'b0;
    tick(2);
    check("kill_sticky", 32'(kill_sts), 32'd1);
    check("kill_sticky_lo", 32'(out_lo), 32'd0);
    kill_clr = 1'b1;
    tick(1);
    kill_clr = 1'b0;
    check("kill_cleared", 32'(kill_sts), 32'd0);
    tick(1);
    check("resume_out_lo", 32'(out_lo), 32'hF);
    run_pulse("resume", 2, 10, 5, 5, 5, 10);

    // output enable
    en = 1'b0;
    tick(1);
    check("en_off_lo", 32'(out_lo), 32'd0);
    en = 1'b1;
    tick(2);
    check("en_on_lo", 32'(out_lo), 32'hF);

    // randomized run with an asynchronous reset in the middle
    for (int cyc = 0; cyc < 1500; cyc++) begin
      @(posedge clk); #1;
      if (cyc == 700) begin
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_hi", 32'(out_hi), 32'd0);
        check("async_rst_lo", 32'(out_lo), 32'd0);
        check("async_rst_ks", 32'(kill_sts), 32'd0);
        check("async_rst_state", 32'(dbg_state), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
      end else begin
        for (int c = 0; c < CH; c++)
          if ($urandom_range(0, 5) == 0) pwm_in[c] = ~pwm_in[c];
        if ($urandom_range(0, 39) == 0) dt_cfg = DW'($urandom_range(0, 6));
        kill     = ($urandom_range(0, 199) == 0);
        kill_clr = ($urandom_range(0, 29) == 0);
        if ($urandom_range(0, 149) == 0) en = ~en;
        else if (!en && $urandom_range(0, 9) == 0) en = 1'b1;
      end
    end

    kill = 1'b0;
    kill_clr = 1'b0;
    tick(3);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
